// File: rtl/note_highway_if.sv
// Play-side signal bundle of the note highway: song/config/buttons in, display and scoring out.
// The parameters must match those of the note_highway instance the bundle is connected to.
interface note_highway_if #(
    parameter int LANES    = 2,
    parameter int SONG_LEN = 32,
    parameter int DISP_LEN = 8,
    parameter int SPEED_W  = 23,
    parameter int SCORE_W  = 8
);
    logic                      start;
    logic [LANES*SONG_LEN-1:0] song;
    logic [SPEED_W-1:0]        beat_period;
    logic [LANES-1:0]          buttons;
    logic [LANES*DISP_LEN-1:0] display;
    logic                      hit;
    logic                      miss;
    logic [SCORE_W-1:0]        streak;
    logic [SCORE_W-1:0]        score;
    logic [SCORE_W-1:0]        num_hits;
    logic [SCORE_W-1:0]        num_misses;
    logic                      done;

    modport master (
        output start, song, beat_period, buttons,
        input  display, hit, miss, streak, score, num_hits, num_misses, done
    );

    modport slave (
        input  start, song, beat_period, buttons,
        output display, hit, miss, streak, score, num_hits, num_misses, done
    );
endinterface

// File: rtl/note_highway.sv
// Rhythm-game note highway: scrolls a latched song through LANES lanes toward the slot-0
// hit zone at a programmable beat and judges synchronised button presses into saturating counters.
module note_highway #(
    parameter int LANES    = 2,
    parameter int SONG_LEN = 32,
    parameter int DISP_LEN = 8,
    parameter int SPEED_W  = 23,
    parameter int SCORE_W  = 8
) (
    input  logic          hwclk,
    input  logic          reset,
    note_highway_if.slave bus
);
    localparam int TICKS = SONG_LEN + DISP_LEN;
    localparam int PTR_W = $clog2(TICKS + 1);
    localparam int CNT_W = $clog2(2 * LANES + 1);
    localparam int SUM_W = SCORE_W + CNT_W + 3;
    localparam logic [SCORE_W-1:0] SAT      = '1;
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(TICKS - 1);
    localparam logic [PTR_W-1:0]   PTR_SONG = PTR_W'(SONG_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [LANES*SONG_LEN-1:0] song_q;
    logic [LANES*DISP_LEN-1:0] disp;
    logic [SPEED_W-1:0]        beat_cnt;
    logic [SPEED_W-1:0]        period_q;
    logic [PTR_W-1:0]          ptr;
    logic [LANES-1:0]          sync1, sync2, sync_d;
    logic [SCORE_W-1:0]        streak_q, score_q, hits_q, misses_q;
    logic                      hit_q, miss_q, done_q;

    logic [SPEED_W-1:0]        period_eff;
    logic                      tick, last_tick;
    logic [LANES-1:0]          slot0, press, lane_hit, press_miss, shift_miss;
    logic [LANES*DISP_LEN-1:0] disp_nxt;
    logic [CNT_W-1:0]          h_cnt, m_cnt;
    logic [SUM_W-1:0]          streak_w;
    logic [2:0]                mult;
    int                        ptr_idx;
    logic [SCORE_W-1:0]        streak_nxt, score_nxt, hits_nxt, misses_nxt;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                    input logic [SUM_W-1:0]   b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + b;
        return (s > SUM_W'(SAT)) ? SAT : s[SCORE_W-1:0];
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        period_eff = (bus.beat_period == '0) ? SPEED_W'(1) : bus.beat_period;
        tick       = (state == PLAY) && (beat_cnt == period_q - SPEED_W'(1));
        last_tick  = tick && (ptr == PTR_LAST);
        ptr_idx    = (ptr < PTR_SONG) ? int'(ptr) : 0;
        slot0      = '0;
        for (int l = 0; l < LANES; l++) begin
            slot0[l] = disp[l*DISP_LEN];
        end
        press      = sync2 & ~sync_d & {LANES{state == PLAY}};
        lane_hit   = press & slot0;
        press_miss = press & ~slot0;
        // A note hit on a tick cycle is already gone, so it cannot also scroll out as a miss.
        shift_miss = tick ? (slot0 & ~lane_hit) : '0;
    end

    always_comb begin
        disp_nxt = disp;
        for (int l = 0; l < LANES; l++) begin
            if (tick) begin
                for (int s = 0; s < DISP_LEN - 1; s++) begin
                    disp_nxt[l*DISP_LEN+s] = disp[l*DISP_LEN+s+1];
                end
                disp_nxt[l*DISP_LEN+DISP_LEN-1] =
                    (ptr < PTR_SONG) ? song_q[l*SONG_LEN+ptr_idx] : 1'b0;
            end else if (lane_hit[l]) begin
                disp_nxt[l*DISP_LEN] = 1'b0;
            end
        end
    end

    always_comb begin
        h_cnt = '0;
        m_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            h_cnt = h_cnt + CNT_W'(lane_hit[l]);
            m_cnt = m_cnt + CNT_W'(press_miss[l]) + CNT_W'(shift_miss[l]);
        end
        // Multiplier uses the streak as it stood before this cycle's judgement.
        streak_w   = SUM_W'(streak_q);
        mult       = (streak_w >= SUM_W'(12)) ? 3'd4 : 3'(streak_w >> 2) + 3'd1;
        score_nxt  = sat_add(score_q, SUM_W'(h_cnt) * SUM_W'(mult));
        hits_nxt   = sat_add(hits_q, SUM_W'(h_cnt));
        misses_nxt = sat_add(misses_q, SUM_W'(m_cnt));
        streak_nxt = (m_cnt != '0) ? '0 : sat_add(streak_q, SUM_W'(h_cnt));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            // NOTE: the song store is reset like any other register; it is flops, not a RAM macro.
            song_q   <= '0;
            disp     <= '0;
            beat_cnt <= '0;
            period_q <= '0;
            ptr      <= '0;
            sync1    <= '0;
            sync2    <= '0;
            sync_d   <= '0;
            streak_q <= '0;
            score_q  <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sync1  <= bus.buttons;
            sync2  <= sync1;
            sync_d <= sync2;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= PLAY;
                        song_q   <= bus.song;
                        disp     <= '0;
                        beat_cnt <= '0;
                        period_q <= period_eff;
                        ptr      <= '0;
                        streak_q <= '0;
                        score_q  <= '0;
                        hits_q   <= '0;
                        misses_q <= '0;
                    end
                end
                PLAY: begin
                    disp     <= disp_nxt;
                    streak_q <= streak_nxt;
                    score_q  <= score_nxt;
                    hits_q   <= hits_nxt;
                    misses_q <= misses_nxt;
                    hit_q    <= (h_cnt != '0);
                    miss_q   <= (m_cnt != '0);
                    if (tick) begin
                        // New beat_period is picked up only at the wrap.
                        beat_cnt <= '0;
                        period_q <= period_eff;
                        ptr      <= ptr + PTR_W'(1);
                        if (last_tick) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + SPEED_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.display    = disp;
    assign bus.hit        = hit_q;
    assign bus.miss       = miss_q;
    assign bus.streak     = streak_q;
    assign bus.score      = score_q;
    assign bus.num_hits   = hits_q;
    assign bus.num_misses = misses_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_note_highway.sv
// Directed bench for note_highway: a default instance plus a narrow-counter twin (SCORE_W=3)
// driven from the same stimulus so saturation is reachable within one song.
module tb_note_highway;
    logic hwclk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   done_seen;

    always #5 hwclk = ~hwclk;

    note_highway_if bus ();
    note_highway_if #(.SCORE_W(3)) bus_s ();

    assign bus_s.start       = bus.start;
    assign bus_s.song        = bus.song;
    assign bus_s.beat_period = bus.beat_period;
    assign bus_s.buttons     = bus.buttons;

    note_highway dut (
        .hwclk (hwclk),
        .reset (reset),
        .bus   (bus)
    );

    note_highway #(.SCORE_W(3)) dut_s (
        .hwclk (hwclk),
        .reset (reset),
        .bus   (bus_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge hwclk);
            cyc++;
        end
    endtask

    task automatic go_to(input int n);
        if (n > cyc) step(n - cyc);
    endtask

    task automatic do_reset();
        @(negedge hwclk);
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.buttons     = '0;
        bus.song        = '0;
        bus.beat_period = 23'd4;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    // Called at a negedge; the following posedge enters PLAY and returns at the negedge after it (cycle 0).
    task automatic start_song(input logic [63:0] s, input logic [22:0] p);
        bus.song        = s;
        bus.beat_period = p;
        bus.start       = 1'b1;
        @(negedge hwclk);
        bus.start = 1'b0;
        cyc       = 0;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.buttons     = '0;
        bus.song        = '0;
        bus.beat_period = 23'd4;

        // Reset state
        do_reset();
        check("rst_display", 32'(bus.display), 32'h0);
        check("rst_score", 32'(bus.score), 32'd0);
        check("rst_flags", {29'd0, bus.hit, bus.miss, bus.done}, 32'd0);
        check("rst_counts", {8'd0, bus.streak, bus.num_hits, bus.num_misses}, 32'd0);

        // Single hit in the hit zone, then a same-cycle hit + empty press
        start_song(64'h3, 23'd4);
        go_to(31);
        bus.buttons = 2'b01;
        go_to(32);
        check("t2_slot0_after_8_ticks", 32'(bus.display), 32'h0003);
        go_to(33);
        bus.buttons = 2'b00;
        go_to(34);
        check("t2_hit", {30'd0, bus.hit, bus.miss}, 32'b10);
        check("t2_score", 32'(bus.score), 32'd1);
        check("t2_hits", 32'(bus.num_hits), 32'd1);
        check("t2_slot0_cleared", 32'(bus.display), 32'h0002);
        go_to(35);
        bus.buttons = 2'b11;
        go_to(36);
        check("t2_no_miss_on_tick", {31'd0, bus.miss}, 32'd0);
        check("t2_misses_after_tick", 32'(bus.num_misses), 32'd0);
        go_to(37);
        bus.buttons = 2'b00;
        go_to(38);
        check("t4_hit_and_miss", {30'd0, bus.hit, bus.miss}, 32'b11);
        check("t4_streak", 32'(bus.streak), 32'd0);
        check("t4_score", 32'(bus.score), 32'd2);
        check("t4_counts", {16'd0, bus.num_hits, bus.num_misses}, {16'd0, 8'd2, 8'd1});
        go_to(40);
        check("t4_hit_note_not_missed", 32'(bus.num_misses), 32'd1);

        // Never press an all-ones song at one tick per cycle
        do_reset();
        start_song('1, 23'd1);
        go_to(4);
        check("t3_disp_4_ticks", 32'(bus.display), 32'hF0F0);
        go_to(8);
        check("t3_disp_8_ticks", 32'(bus.display), 32'hFFFF);
        go_to(9);
        check("t3_first_shift_miss", {23'd0, bus.miss, bus.num_misses}, {23'd0, 1'b1, 8'd2});
        go_to(39);
        check("t3_no_done_early", {23'd0, bus.done, bus.num_misses}, {23'd0, 1'b0, 8'd62});
        go_to(40);
        check("t3_done_pulse", 32'(bus.done), 32'd1);
        check("t3_misses", 32'(bus.num_misses), 32'd64);
        check("t3_streak", 32'(bus.streak), 32'd0);
        check("t3_sat_misses", 32'(bus_s.num_misses), 32'd7);
        go_to(41);
        check("t3_done_one_cycle", 32'(bus.done), 32'd0);
        check("t3_hold_in_done", {16'd0, bus.display}, {16'd0, 16'h0000});
        check("t3_misses_hold", 32'(bus.num_misses), 32'd64);

        // Eight consecutive hits: multiplier steps from 1 to 2 after four
        do_reset();
        start_song(64'hFF, 23'd4);
        for (int k = 0; k < 8; k++) begin
            go_to(31 + 4 * k);
            bus.buttons = 2'b01;
            go_to(33 + 4 * k);
            bus.buttons = 2'b00;
            go_to(34 + 4 * k);
            check($sformatf("t5_hit_%0d", k), 32'(bus.hit), 32'd1);
            if (k == 3) check("t5_score_after_4", 32'(bus.score), 32'd4);
        end
        check("t5_score", 32'(bus.score), 32'd12);
        check("t5_streak", 32'(bus.streak), 32'd8);
        check("t5_hits", 32'(bus.num_hits), 32'd8);
        check("t5_sat_score", 32'(bus_s.score), 32'd7);
        check("t5_sat_streak", 32'(bus_s.streak), 32'd7);
        check("t5_sat_hits", 32'(bus_s.num_hits), 32'd7);
        go_to(64);
        check("t5_no_misses", 32'(bus.num_misses), 32'd0);

        // beat_period 0: press on a tick edge, held button, start ignored in PLAY
        do_reset();
        start_song(64'h1, 23'd0);
        go_to(6);
        bus.buttons = 2'b01;
        go_to(9);
        check("t6_hit_on_tick", {30'd0, bus.hit, bus.miss}, 32'b10);
        check("t6_counts", {16'd0, bus.num_hits, bus.num_misses}, {16'd0, 8'd1, 8'd0});
        check("t6_score", 32'(bus.score), 32'd1);
        go_to(20);
        check("t6_held_one_press", {16'd0, bus.num_hits, bus.num_misses}, {16'd0, 8'd1, 8'd0});
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        go_to(39);
        check("t6_start_ignored", {23'd0, bus.done, bus.num_hits}, {23'd0, 1'b0, 8'd1});
        go_to(40);
        check("t6_done", 32'(bus.done), 32'd1);
        go_to(42);
        bus.buttons = 2'b00;
        go_to(44);
        bus.buttons = 2'b11;
        go_to(46);
        check("t6_no_judge_in_done", {30'd0, bus.hit, bus.miss}, 32'd0);
        go_to(50);
        check("t6_counts_hold", {8'd0, bus.score, bus.num_hits, bus.num_misses},
              {8'd0, 8'd1, 8'd1, 8'd0});
        bus.buttons = 2'b00;

        // Reset in mid-play with notes on screen
        do_reset();
        start_song('1, 23'd4);
        go_to(20);
        check("t1_notes_on_screen", 32'(bus.display), 32'hF8F8);
        reset = 1'b1;
        #1;
        check("t1_async_clear", 32'(bus.display), 32'h0);
        step(1);
        check("t1_flags_clear", {29'd0, bus.hit, bus.miss, bus.done}, 32'd0);
        check("t1_counts_clear", {bus.score, bus.streak, bus.num_hits, bus.num_misses}, 32'd0);
        reset     = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (bus.done) done_seen++;
        end
        check("t1_no_done_after_reset", 32'(done_seen), 32'd0);
        check("t1_idle_no_scroll", 32'(bus.display), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
